// File: rtl/fc_pixel_tx.sv
// rtl/fc_pixel_tx.sv - frame-to-beat serializer feeding the FC layer; optional shadow buffer under FC_TX_DOUBLE_BUF_EN
module fc_pixel_tx #(
    parameter int INPUT_NUM  = 400,
    parameter int LANES      = 16,
    parameter int BEATS      = 25,
    parameter int GAP_CYCLES = 1,
    parameter int BEAT_GAP   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    input  logic [INPUT_NUM-1:0] frame_data,
    output logic                 valid_out,
    output logic                 pixel_out_1,
    output logic                 pixel_out_2,
    output logic                 pixel_out_3,
    output logic                 pixel_out_4,
    output logic                 pixel_out_5,
    output logic                 pixel_out_6,
    output logic                 pixel_out_7,
    output logic                 pixel_out_8,
    output logic                 pixel_out_9,
    output logic                 pixel_out_10,
    output logic                 pixel_out_11,
    output logic                 pixel_out_12,
    output logic                 pixel_out_13,
    output logic                 pixel_out_14,
    output logic                 pixel_out_15,
    output logic                 pixel_out_16,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int SW = (BEAT_GAP > 0) ? $clog2(BEAT_GAP + 1) : 1;
    localparam logic [4:0]    LAST_BEAT = 5'(BEATS - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [SW-1:0] SP_LAST   = SW'(BEAT_GAP);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t                 state, state_n;
    logic [4:0]             beat_cnt, beat_n;
    logic [SW-1:0]          sp_cnt, sp_n;
    logic [GW-1:0]          gap_cnt, gap_n;
    logic [INPUT_NUM-1:0]   active_buf;
    logic                   load_active;
    logic                   accept;
    logic [15:0]            lanes;

`ifdef FC_TX_DOUBLE_BUF_EN
    logic [INPUT_NUM-1:0]   shadow_buf;
    logic                   shadow_full, shadow_full_n;
    logic                   load_shadow;
    logic                   active_from_shadow;

    assign frame_ready = rst_n & ((state == IDLE) | ~shadow_full);
`else
    assign frame_ready = rst_n & (state == IDLE);
`endif

    assign accept     = frame_valid & frame_ready;
    assign valid_out  = (state == SEND) && (sp_cnt == '0);
    assign busy       = (state != IDLE);
    assign frame_done = (state == GAP) && (gap_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            sp_cnt   <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_n;
            beat_cnt <= beat_n;
            sp_cnt   <= sp_n;
            gap_cnt  <= gap_n;
        end
    end

`ifdef FC_TX_DOUBLE_BUF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_full <= 1'b0;
        end else begin
            shadow_full <= shadow_full_n;
        end
    end

    // Frame storage carries no reset; only the shadow's full flag matters after reset.
    always_ff @(posedge clk) begin
        if (load_active) begin
            active_buf <= active_from_shadow ? shadow_buf : frame_data;
        end
        if (load_shadow) begin
            shadow_buf <= frame_data;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (load_active) begin
            active_buf <= frame_data;
        end
    end
`endif

    always_comb begin
        state_n     = state;
        beat_n      = beat_cnt;
        sp_n        = sp_cnt;
        gap_n       = gap_cnt;
        load_active = 1'b0;
`ifdef FC_TX_DOUBLE_BUF_EN
        load_shadow        = 1'b0;
        active_from_shadow = 1'b0;
        shadow_full_n      = shadow_full;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n     = SEND;
                    beat_n      = '0;
                    sp_n        = '0;
                    load_active = 1'b1;
                end
            end
            SEND: begin
                // sp_cnt==0 marks a beat cycle; nonzero values are the inter-beat idle slots.
                if (sp_cnt == '0) begin
                    if (beat_cnt == LAST_BEAT) begin
                        state_n = GAP;
                        beat_n  = '0;
                        gap_n   = '0;
                    end else if (BEAT_GAP == 0) begin
                        beat_n = beat_cnt + 5'd1;
                    end else begin
                        sp_n = SW'(1);
                    end
                end else if (sp_cnt == SP_LAST) begin
                    sp_n   = '0;
                    beat_n = beat_cnt + 5'd1;
                end else begin
                    sp_n = sp_cnt + SW'(1);
                end
`ifdef FC_TX_DOUBLE_BUF_EN
                if (accept) begin
                    load_shadow   = 1'b1;
                    shadow_full_n = 1'b1;
                end
`endif
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_n   = '0;
                    state_n = IDLE;
`ifdef FC_TX_DOUBLE_BUF_EN
                    // A frame arriving on the final gap cycle bypasses the shadow.
                    if (shadow_full) begin
                        state_n            = SEND;
                        load_active        = 1'b1;
                        active_from_shadow = 1'b1;
                        shadow_full_n      = 1'b0;
                    end else if (accept) begin
                        state_n     = SEND;
                        load_active = 1'b1;
                    end
`endif
                end else begin
                    gap_n = gap_cnt + GW'(1);
`ifdef FC_TX_DOUBLE_BUF_EN
                    if (accept) begin
                        load_shadow   = 1'b1;
                        shadow_full_n = 1'b1;
                    end
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Lane k carries bits k*BEATS .. k*BEATS+BEATS-1, one per beat.
    for (genvar k = 0; k < 16; k++) begin : g_lane
        if (k < LANES) begin : g_on
            logic [BEATS-1:0] seg;
            assign seg      = active_buf[k*BEATS +: BEATS];
            assign lanes[k] = valid_out & seg[beat_cnt];
        end else begin : g_off
            assign lanes[k] = 1'b0;
        end
    end

    assign pixel_out_1  = lanes[0];
    assign pixel_out_2  = lanes[1];
    assign pixel_out_3  = lanes[2];
    assign pixel_out_4  = lanes[3];
    assign pixel_out_5  = lanes[4];
    assign pixel_out_6  = lanes[5];
    assign pixel_out_7  = lanes[6];
    assign pixel_out_8  = lanes[7];
    assign pixel_out_9  = lanes[8];
    assign pixel_out_10 = lanes[9];
    assign pixel_out_11 = lanes[10];
    assign pixel_out_12 = lanes[11];
    assign pixel_out_13 = lanes[12];
    assign pixel_out_14 = lanes[13];
    assign pixel_out_15 = lanes[14];
    assign pixel_out_16 = lanes[15];

endmodule

// File: tb/tb_fc_pixel_tx.sv
// tb/tb_fc_pixel_tx.sv - randomized bench with a frame-schedule reference model for fc_pixel_tx
module tb_fc_pixel_tx;

    localparam int INPUT_NUM = 400;
    localparam int BEATS     = 25;
    localparam int GAP       = 1;

    typedef struct {
        int                   start;
        logic [INPUT_NUM-1:0] data;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_valid = 1'b0;
    logic [INPUT_NUM-1:0] frame_data = '0;

    logic r0, v0, d0, b0, r1, v1, d1, b1;
    logic [15:0] p0, p1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    frame_t fq0[$];
    frame_t fq1[$];
    int last_start[2] = '{-1000, -1000};
    int last_free[2]  = '{-1000, -1000};

    always #5 clk = ~clk;

    fc_pixel_tx u0 (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_ready(r0),
        .frame_data(frame_data), .valid_out(v0),
        .pixel_out_1(p0[0]), .pixel_out_2(p0[1]), .pixel_out_3(p0[2]), .pixel_out_4(p0[3]),
        .pixel_out_5(p0[4]), .pixel_out_6(p0[5]), .pixel_out_7(p0[6]), .pixel_out_8(p0[7]),
        .pixel_out_9(p0[8]), .pixel_out_10(p0[9]), .pixel_out_11(p0[10]), .pixel_out_12(p0[11]),
        .pixel_out_13(p0[12]), .pixel_out_14(p0[13]), .pixel_out_15(p0[14]), .pixel_out_16(p0[15]),
        .busy(b0), .frame_done(d0)
    );

    fc_pixel_tx #(.BEAT_GAP(2)) u1 (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_ready(r1),
        .frame_data(frame_data), .valid_out(v1),
        .pixel_out_1(p1[0]), .pixel_out_2(p1[1]), .pixel_out_3(p1[2]), .pixel_out_4(p1[3]),
        .pixel_out_5(p1[4]), .pixel_out_6(p1[5]), .pixel_out_7(p1[6]), .pixel_out_8(p1[7]),
        .pixel_out_9(p1[8]), .pixel_out_10(p1[9]), .pixel_out_11(p1[10]), .pixel_out_12(p1[11]),
        .pixel_out_13(p1[12]), .pixel_out_14(p1[13]), .pixel_out_15(p1[14]), .pixel_out_16(p1[15]),
        .busy(b1), .frame_done(d1)
    );

    // Expected outputs at cycle c from the list of scheduled frames.
    function automatic void model_out(input frame_t q[$], input int c, input int bg,
                                      output logic v, output logic [15:0] p,
                                      output logic dn, output logic bz);
        v = 1'b0; p = '0; dn = 1'b0; bz = 1'b0;
        foreach (q[i]) begin
            int rel, b, dcyc;
            rel  = c - q[i].start - 1;
            dcyc = q[i].start + 1 + (BEATS - 1) * (bg + 1) + 1;
            if (rel >= 0 && rel % (bg + 1) == 0 && rel / (bg + 1) < BEATS) begin
                v = 1'b1;
                b = rel / (bg + 1);
                for (int k = 0; k < 16; k++) p[k] = q[i].data[k*BEATS + b];
            end
            if (c == dcyc) dn = 1'b1;
            if (c > q[i].start && c < dcyc + GAP) bz = 1'b1;
        end
    endfunction

    function automatic logic model_ready(input int d, input int c);
`ifdef FC_TX_DOUBLE_BUF_EN
        return c > last_start[d];
`else
        return (c >= last_free[d]) && (c > last_start[d]);
`endif
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    always @(negedge clk) begin : scoreboard
        logic ev, edn, ebz, er;
        logic [15:0] ep;
        int s;
        if (!rst_n) begin
            fq0.delete();
            fq1.delete();
            last_start = '{-1000, -1000};
            last_free  = '{-1000, -1000};
        end
        model_out(fq0, cyc, 0, ev, ep, edn, ebz);
        er = rst_n && model_ready(0, cyc);
        checks++;
        if ({r0, v0, p0, d0, b0} !== {er, ev, ep, edn, ebz}) begin
            errors++;
            $display("FAIL scoreboard dut0 cyc %0d: got rdy=%b v=%b pix=%h done=%b busy=%b, exp rdy=%b v=%b pix=%h done=%b busy=%b",
                     cyc, r0, v0, p0, d0, b0, er, ev, ep, edn, ebz);
        end
        if (frame_valid && er) begin
            s = max2(cyc, last_free[0] - 1);
            fq0.push_back('{start: s, data: frame_data});
            last_start[0] = s;
            last_free[0]  = s + 1 + (BEATS - 1) + 1 + GAP;
        end
        model_out(fq1, cyc, 2, ev, ep, edn, ebz);
        er = rst_n && model_ready(1, cyc);
        checks++;
        if ({r1, v1, p1, d1, b1} !== {er, ev, ep, edn, ebz}) begin
            errors++;
            $display("FAIL scoreboard dut1 cyc %0d: got rdy=%b v=%b pix=%h done=%b busy=%b, exp rdy=%b v=%b pix=%h done=%b busy=%b",
                     cyc, r1, v1, p1, d1, b1, er, ev, ep, edn, ebz);
        end
        if (frame_valid && er) begin
            s = max2(cyc, last_free[1] - 1);
            fq1.push_back('{start: s, data: frame_data});
            last_start[1] = s;
            last_free[1]  = s + 1 + (BEATS - 1) * 3 + 1 + GAP;
        end
        while (fq0.size() > 3) void'(fq0.pop_front());
        while (fq1.size() > 3) void'(fq1.pop_front());
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        frame_valid = 1'b0;
        repeat (n) tick();
    endtask

    function automatic logic [INPUT_NUM-1:0] rand_frame();
        logic [INPUT_NUM-1:0] f;
        for (int i = 0; i < INPUT_NUM; i += 32) f[i +: 16] = 16'($urandom);
        for (int i = 16; i < INPUT_NUM; i += 32) f[i +: 16] = 16'($urandom);
        return f;
    endfunction

    task automatic test_reset();
        logic [INPUT_NUM-1:0] f;
        logic [15:0] ep;
        int nv, nd;
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({v0, p0, d0, b0, r0} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {v0, p0, d0, b0, r0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (r0 !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got %b required 1", r0);
        end
        tick();
        // Start a frame, then pull reset while beat 10 is on the lanes.
        frame_valid = 1'b1;
        frame_data  = rand_frame();
        tick();
        frame_valid = 1'b0;
        repeat (10) tick();
        checks++;
        if (v0 !== 1'b1) begin
            errors++;
            $display("FAIL beat10_present: got %b required 1", v0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({v0, p0, d0, b0, r0} !== 20'h0) begin
            errors++;
            $display("FAIL midframe_reset_outputs: got %h required 0", {v0, p0, d0, b0, r0});
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (r0 !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_midframe_release: got %b required 1", r0);
        end
        nv = 0; nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (v0) nv++;
            if (d0) nd++;
        end
        checks++;
        if (nv != 0 || nd != 0) begin
            errors++;
            $display("FAIL aborted_frame_silent: got beats=%0d done=%0d required 0 0", nv, nd);
        end
        tick();
        f = rand_frame();
        frame_data  = f;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            @(negedge clk);
            for (int k = 0; k < 16; k++) ep[k] = f[k*BEATS + b];
            checks++;
            if ({v0, p0} !== {1'b1, ep}) begin
                errors++;
                $display("FAIL restart_beat%0d: got v=%b pix=%h required v=1 pix=%h", b, v0, p0, ep);
            end
        end
    endtask

    task automatic test_single_frame();
        int nv, firstv, lastv, n1, rel1, n16, rel16, other, nd, reld;
        idle(100);
        frame_data = '0;
        frame_data[0]   = 1'b1;
        frame_data[399] = 1'b1;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        nv = 0; firstv = -1; lastv = -1; n1 = 0; rel1 = -1; n16 = 0; rel16 = -1;
        other = 0; nd = 0; reld = -1;
        for (int rel = 1; rel <= 30; rel++) begin
            @(negedge clk);
            if (v0) begin
                nv++;
                if (firstv < 0) firstv = rel;
                lastv = rel;
            end
            if (p0[0])  begin n1++;  rel1  = rel; end
            if (p0[15]) begin n16++; rel16 = rel; end
            if (|p0[14:1]) other++;
            if (d0) begin nd++; reld = rel; end
        end
        checks++;
        if (nv != 25 || firstv != 1 || lastv != 25) begin
            errors++;
            $display("FAIL single_valid_window: got n=%0d first=%0d last=%0d required 25 1 25", nv, firstv, lastv);
        end
        checks++;
        if (n1 != 1 || rel1 != 1) begin
            errors++;
            $display("FAIL single_lane1: got n=%0d at=%0d required 1 at 1", n1, rel1);
        end
        checks++;
        if (n16 != 1 || rel16 != 25) begin
            errors++;
            $display("FAIL single_lane16: got n=%0d at=%0d required 1 at 25", n16, rel16);
        end
        checks++;
        if (other != 0) begin
            errors++;
            $display("FAIL single_other_lanes: got %0d required 0", other);
        end
        checks++;
        if (nd != 1 || reld != 26) begin
            errors++;
            $display("FAIL single_done: got n=%0d at=%0d required 1 at 26", nd, reld);
        end
    endtask

    task automatic test_back_to_back();
        logic rdy[0:40];
        logic vh[0:40];
        int acc[$];
        int bad;
        idle(100);
        frame_data  = rand_frame();
        frame_valid = 1'b1;
        for (int rel = 0; rel <= 40; rel++) begin
            @(negedge clk);
            rdy[rel] = r0;
            vh[rel]  = v0;
            if (r0 && frame_valid) acc.push_back(rel);
            @(posedge clk);
            #1;
            if (acc.size() == 1) frame_data = rand_frame();
            if (acc.size() >= 2) frame_valid = 1'b0;
        end
        bad = 0;
`ifdef FC_TX_DOUBLE_BUF_EN
        for (int rel = 2; rel <= 26; rel++) if (rdy[rel] !== 1'b0) bad++;
        checks++;
        if (acc.size() < 2 || acc[0] != 0 || acc[1] != 1) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d accepts first=%0d second=%0d required 0 1",
                     acc.size(), (acc.size() > 0) ? acc[0] : -1, (acc.size() > 1) ? acc[1] : -1);
        end
        checks++;
        if (vh[26] !== 1'b0 || vh[27] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_beat0: got v26=%b v27=%b required 0 1", vh[26], vh[27]);
        end
`else
        for (int rel = 1; rel <= 26; rel++) if (rdy[rel] !== 1'b0) bad++;
        checks++;
        if (acc.size() < 2 || acc[0] != 0 || acc[1] != 27) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d accepts first=%0d second=%0d required 0 27",
                     acc.size(), (acc.size() > 0) ? acc[0] : -1, (acc.size() > 1) ? acc[1] : -1);
        end
        checks++;
        if (vh[27] !== 1'b0 || vh[28] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_beat0: got v27=%b v28=%b required 0 1", vh[27], vh[28]);
        end
`endif
        checks++;
        if (bad != 0 || rdy[27] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_window: got %0d busy-cycle ready highs, rdy27=%b required 0 and 1", bad, rdy[27]);
        end
    endtask

    task automatic test_beat_gap();
        int nv, firstv, lastv, badsp, nd, reld;
        idle(100);
        frame_data  = rand_frame();
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        nv = 0; firstv = -1; lastv = -1; badsp = 0; nd = 0; reld = -1;
        for (int rel = 1; rel <= 80; rel++) begin
            @(negedge clk);
            if (v1) begin
                nv++;
                if (firstv < 0) firstv = rel;
                lastv = rel;
                if ((rel - 1) % 3 != 0) badsp++;
            end else if (p1 !== 16'h0) begin
                badsp++;
            end
            if (d1) begin nd++; reld = rel; end
        end
        checks++;
        if (nv != 25 || firstv != 1 || lastv != 73 || badsp != 0) begin
            errors++;
            $display("FAIL beatgap_spacing: got n=%0d first=%0d last=%0d bad=%0d required 25 1 73 0",
                     nv, firstv, lastv, badsp);
        end
        checks++;
        if (nd != 1 || reld != 74) begin
            errors++;
            $display("FAIL beatgap_done: got n=%0d at=%0d required 1 at 74", nd, reld);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 700; i++) begin
            frame_valid = ($urandom_range(0, 99) < 40);
            frame_data  = rand_frame();
            rst_n       = ($urandom_range(0, 249) != 0);
            tick();
        end
        rst_n = 1'b1;
        idle(100);
        checks++;
        if ({r0, b0, r1, b1} !== 4'b1010) begin
            errors++;
            $display("FAIL random_drain: got r0=%b b0=%b r1=%b b1=%b required 1 0 1 0", r0, b0, r1, b1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_beat_gap();
        test_random();
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
